// File: rtl/bcd_operand_entry_if.sv
// rtl/bcd_operand_entry_if.sv - switch/button entry and ALU-side result bundle for bcd_operand_entry
interface bcd_operand_entry_if #(
    parameter int N      = 12,
    parameter int DIGITS = 3,
    parameter int OP_W   = 11,
    parameter int OPC_W  = 4
);
    localparam int SW_W = ((4 * DIGITS > OP_W) ? 4 * DIGITS : OP_W) + 1;

    logic                    start;
    logic                    but0;
    logic [SW_W-1:0]         sw;
    logic signed [N-1:0]     a;
    logic signed [N-1:0]     b;
    logic [OPC_W-1:0]        opcode;
    logic                    done;
    logic                    err;
    logic                    busy;
    logic [2:0]              phase;

    modport master (
        output start, but0, sw,
        input  a, b, opcode, done, err, busy, phase
    );

    modport slave (
        input  start, but0, sw,
        output a, b, opcode, done, err, busy, phase
    );
endinterface

// File: rtl/bcd_operand_entry.sv
// rtl/bcd_operand_entry.sv - sign-magnitude BCD operand/opcode entry with debounced confirm button
module bcd_operand_entry #(
    parameter int               N          = 12,
    parameter int               DIGITS     = 3,
    parameter int               OP_W       = 11,
    parameter int               OPC_W      = 4,
    parameter logic [OP_W-1:0]  UNARY_MASK = 11'b00001000000,
    parameter int               DEB_CYCLES = 4
) (
    input logic               CLK,
    input logic               RST,
    bcd_operand_entry_if.slave bus
);
    localparam int ACC_W = 4 * DIGITS;
    localparam int CMP_W = ((ACC_W > N) ? ACC_W : N) + 1;
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int OCW   = $clog2(OP_W + 1);
    localparam logic [CMP_W-1:0] MAX_MAG = (CMP_W'(1) << (N - 1)) - CMP_W'(1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] GET_A  = 3'd1;
    localparam logic [2:0] CONV_A = 3'd2;
    localparam logic [2:0] GET_OP = 3'd3;
    localparam logic [2:0] GET_B  = 3'd4;
    localparam logic [2:0] CONV_B = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;
    localparam logic [2:0] ERR    = 3'd7;

    logic              sync1, sync2, deb, deb_d;
    logic [DEB_W-1:0]  deb_cnt;
    logic              press;

    logic [2:0]        phase;
    logic [N-1:0]      a_q, b_q;
    logic [OPC_W-1:0]  opcode_q;
    logic [ACC_W-1:0]  dig_q, acc, acc_next;
    logic              sign_q;
    logic [IDX_W-1:0]  dig_idx;

    logic              bad_digit;
    logic [OCW-1:0]    op_cnt;
    logic [OPC_W-1:0]  op_idx;
    logic              too_big;
    logic [N-1:0]      mag_n, val;

    // Two-flop synchroniser then a level debouncer; press is the rising edge of the clean level
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            deb     <= 1'b0;
            deb_d   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1 <= bus.but0;
            sync2 <= sync1;
            deb_d <= deb;
            if (sync2 == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                deb     <= sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    assign press = deb & ~deb_d;

    // Field decode of the live switches: digit validity, one-hot count and set-bit index
    always_comb begin
        bad_digit = 1'b0;
        op_cnt    = '0;
        op_idx    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.sw[4*i+1 +: 4] > 4'd9) bad_digit = 1'b1;
        end
        for (int i = 0; i < OP_W; i++) begin
            if (bus.sw[i+1]) begin
                op_cnt = op_cnt + OCW'(1);
                op_idx = OPC_W'(i);
            end
        end
    end

    // One Horner step per cycle on the latched digits (MS nibble sits at the top of dig_q)
    always_comb begin
        acc_next = ACC_W'(acc * ACC_W'(10)) + ACC_W'(dig_q[ACC_W-1 -: 4]);
        too_big  = CMP_W'(acc_next) > MAX_MAG;
        mag_n    = N'(acc_next);
        val      = sign_q ? (N'(0) - mag_n) : mag_n;
    end

    // Entry sequencer: latch on press, convert, range-check, publish or reject
    always_ff @(posedge CLK) begin
        if (RST) begin
            phase    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            opcode_q <= '0;
            dig_q    <= '0;
            acc      <= '0;
            sign_q   <= 1'b0;
            dig_idx  <= '0;
        end else begin
            case (phase)
                IDLE, DONE, ERR: begin
                    if (bus.start) begin
                        phase    <= GET_A;
                        a_q      <= '0;
                        b_q      <= '0;
                        opcode_q <= '0;
                    end
                end
                GET_A, GET_B: begin
                    if (press) begin
                        if (bad_digit) begin
                            phase <= ERR;
                        end else begin
                            dig_q   <= bus.sw[ACC_W:1];
                            sign_q  <= bus.sw[0];
                            acc     <= '0;
                            dig_idx <= '0;
                            phase   <= (phase == GET_A) ? CONV_A : CONV_B;
                        end
                    end
                end
                CONV_A, CONV_B: begin
                    acc     <= acc_next;
                    dig_q   <= dig_q << 4;
                    dig_idx <= dig_idx + IDX_W'(1);
                    if (dig_idx == IDX_W'(DIGITS - 1)) begin
                        if (too_big) begin
                            phase <= ERR;
                        end else if (phase == CONV_A) begin
                            a_q   <= val;
                            phase <= GET_OP;
                        end else begin
                            b_q   <= val;
                            phase <= DONE;
                        end
                    end
                end
                GET_OP: begin
                    if (press) begin
                        if (op_cnt != OCW'(1)) begin
                            phase <= ERR;
                        end else begin
                            opcode_q <= op_idx;
                            if (UNARY_MASK[op_idx]) begin
                                b_q   <= '0;
                                phase <= DONE;
                            end else begin
                                phase <= GET_B;
                            end
                        end
                    end
                end
                default: phase <= IDLE;
            endcase
        end
    end

    assign bus.a      = a_q;
    assign bus.b      = b_q;
    assign bus.opcode = opcode_q;
    assign bus.phase  = phase;
    assign bus.done   = (phase == DONE);
    assign bus.err    = (phase == ERR);
    assign bus.busy   = !((phase == IDLE) || (phase == DONE) || (phase == ERR));
endmodule
